// File: rtl/yolo_pool_pkg.sv
// Shared FP16 types, constants and helpers for the YOLO pooling datapath.
package yolo_pool_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_POS_ZERO = 16'h0000;
  localparam fp16_t FP16_NEG_INF  = 16'hFC00;
  localparam fp16_t FP16_QNAN     = 16'h7E00;

  function automatic logic fp16_is_nan(input fp16_t x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
  endfunction

  // Negative values (including -0 and -inf) and NaNs clamp to +0.
  function automatic fp16_t fp16_relu(input fp16_t x);
    return (x[15] || fp16_is_nan(x)) ? FP16_POS_ZERO : x;
  endfunction

endpackage

// File: rtl/fp16_max2.sv
// Combinational FP16 maximum. a_i is the incumbent: it is kept on ties (+0 vs -0).
module fp16_max2
  import yolo_pool_pkg::*;
(
  input  fp16_t a_i,
  input  fp16_t b_i,
  output fp16_t y_o
);

  logic a_nan, b_nan, b_gt;

  always_comb begin
    a_nan = fp16_is_nan(a_i);
    b_nan = fp16_is_nan(b_i);
    // Sign-magnitude order; both zeros compare equal regardless of sign.
    if ((a_i[14:0] == 15'h0000) && (b_i[14:0] == 15'h0000)) begin
      b_gt = 1'b0;
    end else if (a_i[15] != b_i[15]) begin
      b_gt = a_i[15];
    end else if (!a_i[15]) begin
      b_gt = b_i[14:0] > a_i[14:0];
    end else begin
      b_gt = b_i[14:0] < a_i[14:0];
    end

    if (a_nan && b_nan) begin
      y_o = FP16_QNAN;
    end else if (a_nan) begin
      y_o = b_i;
    end else if (b_nan) begin
      y_o = a_i;
    end else begin
      y_o = b_gt ? b_i : a_i;
    end
  end

endmodule

// File: rtl/maxpool_stream.sv
// Streaming FP16 max-pool over non-overlapping POOL_K x POOL_K windows, raster-order input.
// Define MAXPOOL_RELU_EN to clamp negative/NaN pooled values to +0 at the output register.
module maxpool_stream
  import yolo_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned IMG_H      = 13,
  parameter int unsigned IMG_W      = 13,
  parameter int unsigned POOL_K     = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sof,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_last
);

  localparam int unsigned PixW = CHANNELS * DATA_WIDTH;
  localparam int unsigned OW   = IMG_W / POOL_K;
  localparam int unsigned OH   = IMG_H / POOL_K;
  localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned KW   = (POOL_K > 1) ? $clog2(POOL_K) : 1;
  localparam int unsigned OxW  = $clog2(OW + 1);
  localparam int unsigned OyW  = $clog2(OH + 1);
  localparam int unsigned IdxW = (OW > 1) ? $clog2(OW) : 1;

  if (DATA_WIDTH != 16) begin : g_bad_width
    $error("maxpool_stream: DATA_WIDTH must be 16 (FP16 only)");
  end
  if ((POOL_K < 1) || (POOL_K > IMG_H) || (POOL_K > IMG_W)) begin : g_bad_pool
    $error("maxpool_stream: POOL_K must be in 1..min(IMG_H, IMG_W)");
  end

  logic [ColW-1:0] col_q, col_d, col_c;
  logic [RowW-1:0] row_q, row_d, row_c;
  logic [KW-1:0]   kx_q, kx_d, kx_c, ky_q, ky_d, ky_c;
  logic [OxW-1:0]  ox_q, ox_d, ox_c;
  logic [OyW-1:0]  oy_q, oy_d, oy_c;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [PixW-1:0] out_data_q, out_data_d;

  logic            accept, restart, in_win, first_px, last_px;
  logic [IdxW-1:0] rd_idx;
  logic [PixW-1:0] entry, max_pix, merged, pooled;
  logic [PixW-1:0] buf_q [OW];

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign restart  = accept && in_sof;

  // Effective position of the beat being accepted: in_sof snaps it to (0,0).
  always_comb begin
    col_c = restart ? '0 : col_q;
    row_c = restart ? '0 : row_q;
    kx_c  = restart ? '0 : kx_q;
    ky_c  = restart ? '0 : ky_q;
    ox_c  = restart ? '0 : ox_q;
    oy_c  = restart ? '0 : oy_q;
  end

  // ox/oy saturate at OW/OH over the discarded right/bottom edge.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    kx_d  = kx_q;
    ky_d  = ky_q;
    ox_d  = ox_q;
    oy_d  = oy_q;
    if (accept) begin
      if (col_c == ColW'(IMG_W - 1)) begin
        col_d = '0;
        kx_d  = '0;
        ox_d  = '0;
        if (row_c == RowW'(IMG_H - 1)) begin
          row_d = '0;
          ky_d  = '0;
          oy_d  = '0;
        end else begin
          row_d = row_c + 1'b1;
          if (ky_c == KW'(POOL_K - 1)) begin
            ky_d = '0;
            oy_d = oy_c + 1'b1;
          end else begin
            ky_d = ky_c + 1'b1;
            oy_d = oy_c;
          end
        end
      end else begin
        col_d = col_c + 1'b1;
        row_d = row_c;
        ky_d  = ky_c;
        oy_d  = oy_c;
        if (kx_c == KW'(POOL_K - 1)) begin
          kx_d = '0;
          ox_d = ox_c + 1'b1;
        end else begin
          kx_d = kx_c + 1'b1;
          ox_d = ox_c;
        end
      end
    end
  end

  assign in_win   = (ox_c < OxW'(OW)) && (oy_c < OyW'(OH));
  assign first_px = (kx_c == '0) && (ky_c == '0);
  assign last_px  = (kx_c == KW'(POOL_K - 1)) && (ky_c == KW'(POOL_K - 1));
  assign rd_idx   = IdxW'(ox_c);
  assign entry    = buf_q[rd_idx];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    fp16_max2 u_max (
      .a_i (entry[c*DATA_WIDTH +: DATA_WIDTH]),
      .b_i (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .y_o (max_pix[c*DATA_WIDTH +: DATA_WIDTH])
    );
    assign merged[c*DATA_WIDTH +: DATA_WIDTH] = first_px ? in_data[c*DATA_WIDTH +: DATA_WIDTH]
                                                         : max_pix[c*DATA_WIDTH +: DATA_WIDTH];
`ifdef MAXPOOL_RELU_EN
    assign pooled[c*DATA_WIDTH +: DATA_WIDTH] = fp16_relu(merged[c*DATA_WIDTH +: DATA_WIDTH]);
`else
    assign pooled[c*DATA_WIDTH +: DATA_WIDTH] = merged[c*DATA_WIDTH +: DATA_WIDTH];
`endif
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept && in_win && last_px) begin
      out_valid_d = 1'b1;
      out_data_d  = pooled;
      out_last_d  = (ox_c == OxW'(OW - 1)) && (oy_c == OyW'(OH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Partial maxima need no reset: each entry is overwritten at the window's first pixel.
  always_ff @(posedge clk) begin
    if (accept && in_win) begin
      buf_q[rd_idx] <= merged;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed bench for maxpool_stream: global pool, 2-channel 4x4/K=2, edge discard,
// back-pressure, in_sof restart, mid-frame reset, FP16 corner cases and output clamp.
`timescale 1ns/1ps
module tb_maxpool_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_in_sof, a_out_valid, a_out_last;
  logic [15:0] a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_in_sof, b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_in_data, b_out_data;
  logic        c_in_valid, c_in_ready, c_in_sof, c_out_valid, c_out_last;
  logic [15:0] c_in_data, c_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] qa[$];
  logic [32:0] qb[$];
  logic [16:0] qc[$];
  logic [32:0] exp2 [4];

  logic [15:0] ftab [16] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500,
                             16'h4600, 16'h4700, 16'h4800, 16'h4880, 16'h4900, 16'h4980,
                             16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80};

  maxpool_stream #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_H(13), .IMG_W(13), .POOL_K(13)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sof(a_in_sof),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(1'b1), .out_data(a_out_data),
    .out_last(a_out_last)
  );

  maxpool_stream #(.DATA_WIDTH(16), .CHANNELS(2), .IMG_H(4), .IMG_W(4), .POOL_K(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last)
  );

  maxpool_stream #(.DATA_WIDTH(16), .CHANNELS(1), .IMG_H(5), .IMG_W(5), .POOL_K(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sof(c_in_sof),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(1'b1), .out_data(c_out_data),
    .out_last(c_out_last)
  );

  // Handshakes are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n && a_out_valid) qa.push_back({a_out_last, a_out_data});
    if (rst_n && b_out_valid && b_out_ready) qb.push_back({b_out_last, b_out_data});
    if (rst_n && c_out_valid) qc.push_back({c_out_last, c_out_data});
  end

  function automatic logic [15:0] relu_exp(input logic [15:0] x);
`ifdef MAXPOOL_RELU_EN
    if (x[15] || ((x[14:10] == 5'h1F) && (x[9:0] != 10'h000))) return 16'h0000;
`endif
    return x;
  endfunction

  task automatic send_a(input logic [15:0] d, input logic sof);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = d; a_in_sof = sof;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_sof = 1'b0;
  endtask

  task automatic send_c(input logic [15:0] d, input logic sof);
    @(negedge clk);
    c_in_valid = 1'b1; c_in_data = d; c_in_sof = sof;
    @(posedge clk); #1;
    c_in_valid = 1'b0; c_in_sof = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic sof);
    int guard = 0;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = d; b_in_sof = sof;
    while (!b_in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!b_in_ready) begin
      n_fail++;
      $display("FAIL send_b_ready: in_ready=%b required 1 within 200 cycles", b_in_ready);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_sof = 1'b0;
  endtask

  task automatic send_b_scn2(input int first, input int last, input logic sof_first);
    for (int i = first; i <= last; i++) begin
      send_b({ftab[i] ^ 16'h8000, ftab[i]}, sof_first && (i == first));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({a_out_valid, a_out_last, a_out_data} !== 18'h0) begin
      n_fail++; $display("FAIL reset_a: got %b/%b/%h required 0/0/0000",
                         a_out_valid, a_out_last, a_out_data);
    end
    n_checks++;
    if ({b_out_valid, b_out_last, b_out_data, b_in_ready} !== 35'h1) begin
      n_fail++; $display("FAIL reset_b: got v=%b l=%b d=%h rdy=%b required 0/0/0/1",
                         b_out_valid, b_out_last, b_out_data, b_in_ready);
    end
    n_checks++;
    if ({c_out_valid, c_out_last, c_out_data} !== 18'h0) begin
      n_fail++; $display("FAIL reset_c: got %b/%b/%h required 0/0/0000",
                         c_out_valid, c_out_last, c_out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_global_pool();
    qa.delete();
    for (int i = 0; i < 168; i++) send_a((i == 7 * 13 + 3) ? 16'h4500 : 16'h4000, i == 0);
    n_checks++;
    if (a_out_valid !== 1'b0 || qa.size() != 0) begin
      n_fail++; $display("FAIL global_early: out_valid=%b outputs=%0d required 0/0",
                         a_out_valid, qa.size());
    end
    send_a(16'h4000, 1'b0);
    n_checks++;
    if ({a_out_valid, a_out_last, a_out_data} !== {2'b11, 16'h4500}) begin
      n_fail++; $display("FAIL global_out: got v=%b l=%b d=%h required 1/1/4500",
                         a_out_valid, a_out_last, a_out_data);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (qa.size() != 1) begin
      n_fail++; $display("FAIL global_count: got %0d outputs required 1", qa.size());
    end
  endtask

  task automatic test_chan_pool();
    qb.delete();
    send_b_scn2(0, 15, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (qb.size() != 4) begin
      n_fail++; $display("FAIL chan_count: got %0d outputs required 4", qb.size());
    end
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      n_checks++;
      if (qb[i] !== exp2[i]) begin
        n_fail++; $display("FAIL chan_out%0d: got %h required %h", i, qb[i], exp2[i]);
      end
    end
  endtask

  task automatic test_edge_discard();
    logic [16:0] exp_c [4];
    exp_c = '{{1'b0, 16'h3C06}, {1'b0, 16'h3C08}, {1'b0, 16'h3C10}, {1'b1, 16'h3C12}};
    qc.delete();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        send_c((r == 4 || c == 4) ? 16'h7BFF : (16'h3C00 | 16'(r * 5 + c)), r == 0 && c == 0);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (qc.size() != 4) begin
      n_fail++; $display("FAIL edge_count: got %0d outputs required 4", qc.size());
    end
    for (int i = 0; i < 4 && i < qc.size(); i++) begin
      n_checks++;
      if (qc[i] !== exp_c[i]) begin
        n_fail++; $display("FAIL edge_out%0d: got %h required %h", i, qc[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    qb.delete();
    b_out_ready = 1'b0;
    fork
      send_b_scn2(0, 15, 1'b1);
      begin
        int guard = 0;
        logic [31:0] held;
        while (!b_out_valid && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        n_checks++;
        if (!b_out_valid) begin
          n_fail++; $display("FAIL bp_first: out_valid=%b required 1", b_out_valid);
        end
        held = b_out_data;
        repeat (5) begin
          @(negedge clk);
          n_checks++;
          if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1 || b_out_data !== held) begin
            n_fail++; $display("FAIL bp_hold: rdy=%b v=%b d=%h required 0/1/%h",
                               b_in_ready, b_out_valid, b_out_data, held);
          end
        end
        @(posedge clk); #1;
        b_out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (qb.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d outputs required 4", qb.size());
    end
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      n_checks++;
      if (qb[i] !== exp2[i]) begin
        n_fail++; $display("FAIL bp_out%0d: got %h required %h", i, qb[i], exp2[i]);
      end
    end
  endtask

  task automatic test_sof_restart();
    qb.delete();
    for (int i = 0; i < 5; i++) send_b(32'h7000_7000, i == 0);
    send_b_scn2(0, 15, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (qb.size() != 4) begin
      n_fail++; $display("FAIL sof_count: got %0d outputs required 4", qb.size());
    end
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      n_checks++;
      if (qb[i] !== exp2[i]) begin
        n_fail++; $display("FAIL sof_out%0d: got %h required %h", i, qb[i], exp2[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    b_out_ready = 1'b0;
    send_b_scn2(0, 5, 1'b1);
    n_checks++;
    if (b_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mrst_pending: out_valid=%b required 1", b_out_valid);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({b_out_valid, b_out_last, b_out_data} !== 34'h0) begin
      n_fail++; $display("FAIL mrst_clear: got v=%b l=%b d=%h required 0/0/0",
                         b_out_valid, b_out_last, b_out_data);
    end
    rst_n = 1'b1;
    b_out_ready = 1'b1;
    qb.delete();
    send_b_scn2(0, 15, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (qb.size() != 4) begin
      n_fail++; $display("FAIL mrst_count: got %0d outputs required 4", qb.size());
    end
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      n_checks++;
      if (qb[i] !== exp2[i]) begin
        n_fail++; $display("FAIL mrst_out%0d: got %h required %h", i, qb[i], exp2[i]);
      end
    end
  endtask

  task automatic test_fp16_corners();
    logic [15:0] corner [16];
    logic [15:0] exp_ch0 [4];
    logic [32:0] want;
    int r, c, w, k;
    corner = '{16'h7E00, 16'h3C00, 16'hBC00, 16'h7C01, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00,
               16'h7E00, 16'h7D00, 16'hFE00, 16'h7C01, 16'h8000, 16'h0000, 16'h8000, 16'h8000};
    exp_ch0 = '{16'h3C00, 16'hFC00, 16'h7E00, 16'h8000};
    qb.delete();
    for (int i = 0; i < 16; i++) begin
      r = i / 4; c = i % 4;
      w = (r / 2) * 2 + c / 2;
      k = (r % 2) * 2 + c % 2;
      send_b({(k == 0) ? 16'h0000 : 16'h8000, corner[w * 4 + k]}, i == 0);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (qb.size() != 4) begin
      n_fail++; $display("FAIL fp16_count: got %0d outputs required 4", qb.size());
    end
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      want = {i == 3, 16'h0000, relu_exp(exp_ch0[i])};
      n_checks++;
      if (qb[i] !== want) begin
        n_fail++; $display("FAIL fp16_out%0d: got %h required %h", i, qb[i], want);
      end
    end
  endtask

  task automatic test_relu();
    logic [32:0] want;
    qb.delete();
    for (int i = 0; i < 16; i++) send_b(32'hC000_C000, i == 0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (qb.size() != 4) begin
      n_fail++; $display("FAIL relu_count: got %0d outputs required 4", qb.size());
    end
    for (int i = 0; i < 4 && i < qb.size(); i++) begin
      want = {i == 3, relu_exp(16'hC000), relu_exp(16'hC000)};
      n_checks++;
      if (qb[i] !== want) begin
        n_fail++; $display("FAIL relu_out%0d: got %h required %h", i, qb[i], want);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_sof = 1'b0; a_in_data = '0;
    b_in_valid = 1'b0; b_in_sof = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_sof = 1'b0; c_in_data = '0;
    exp2[0] = {1'b0, relu_exp(16'h8000), 16'h4500};
    exp2[1] = {1'b0, relu_exp(16'hC000), 16'h4700};
    exp2[2] = {1'b0, relu_exp(16'hC800), 16'h4A80};
    exp2[3] = {1'b1, relu_exp(16'hC900), 16'h4B80};

    test_reset();
    test_global_pool();
    test_chan_pool();
    test_edge_discard();
    test_back_pressure();
    test_sof_restart();
    test_mid_reset();
    test_fp16_corners();
    test_relu();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
